// File: rtl/nios2_cordic_pkg.sv
// Shared definitions for the Nios II CORDIC controller: register offsets,
// CTRL/STATUS bit positions and the sequencing FSM encoding.
package nios2_cordic_pkg;

  localparam logic [2:0] REG_ANGLE  = 3'd0;
  localparam logic [2:0] REG_CTRL   = 3'd1;
  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_COS    = 3'd3;
  localparam logic [2:0] REG_SIN    = 3'd4;
  localparam logic [2:0] REG_ITER   = 3'd5;

  localparam int CTRL_GO     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_AUTO   = 2;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_TMO  = 2;
  localparam int ST_OVR  = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/nios2_cordic_ctrl_regs.sv
// Avalon-MM decode, register file, sticky W1C status bits and the
// registered interrupt for the CORDIC controller.
module nios2_cordic_ctrl_regs
  import nios2_cordic_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  input  logic              read,
  output logic [DATA_W-1:0] readdata,
  input  logic              i_busy,
  input  logic              i_capture,
  input  logic              i_timeout,
  input  logic [DATA_W-1:0] i_cos,
  input  logic [DATA_W-1:0] i_sin,
  output logic              o_start,
  output logic [DATA_W-1:0] o_start_angle,
  output logic              o_irq
);

  logic [DATA_W-1:0] r_angle;
  logic [DATA_W-1:0] r_cos;
  logic [DATA_W-1:0] r_sin;
  logic [DATA_W-1:0] r_iter;
  logic              r_irq_en;
  logic              r_auto;
  logic              r_done;
  logic              r_tmo;
  logic              r_ovr;
  logic              r_irq;

  logic w_wr;
  logic w_wr_angle;
  logic w_wr_ctrl;
  logic w_wr_status;
  logic w_go;
  logic w_start_req;
  logic w_overrun;
  logic w_done_nxt;
  logic w_tmo_nxt;
  logic w_ovr_nxt;
  logic w_irq_en_nxt;

  assign w_wr        = chipselect & write;
  assign w_wr_angle  = w_wr & (address == REG_ANGLE);
  assign w_wr_ctrl   = w_wr & (address == REG_CTRL);
  assign w_wr_status = w_wr & (address == REG_STATUS);
  assign w_go        = w_wr_ctrl & writedata[CTRL_GO];
  assign w_start_req = w_go | (w_wr_angle & r_auto);

  // Any ANGLE write or GO while an operation is in flight is dropped and flagged.
  assign w_overrun     = i_busy & (w_wr_angle | w_go);
  assign o_start       = w_start_req & ~i_busy;
  assign o_start_angle = w_wr_angle ? writedata : r_angle;

  // Set wins over a simultaneous write-one-to-clear.
  assign w_done_nxt   = i_capture | (r_done & ~(w_wr_status & writedata[ST_DONE]));
  assign w_tmo_nxt    = i_timeout | (r_tmo  & ~(w_wr_status & writedata[ST_TMO]));
  assign w_ovr_nxt    = w_overrun | (r_ovr  & ~(w_wr_status & writedata[ST_OVR]));
  assign w_irq_en_nxt = w_wr_ctrl ? writedata[CTRL_IRQ_EN] : r_irq_en;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_angle  <= '0;
      r_cos    <= '0;
      r_sin    <= '0;
      r_iter   <= '0;
      r_irq_en <= 1'b0;
      r_auto   <= 1'b0;
      r_done   <= 1'b0;
      r_tmo    <= 1'b0;
      r_ovr    <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_angle && !i_busy) r_angle <= writedata;
      if (w_wr_ctrl) begin
        r_irq_en <= writedata[CTRL_IRQ_EN];
        r_auto   <= writedata[CTRL_AUTO];
      end
      if (i_capture) begin
        r_cos  <= i_cos;
        r_sin  <= i_sin;
        r_iter <= r_iter + 1'b1;
      end
      r_done <= w_done_nxt;
      r_tmo  <= w_tmo_nxt;
      r_ovr  <= w_ovr_nxt;
      r_irq  <= w_irq_en_nxt & (w_done_nxt | w_tmo_nxt);
    end
  end

  assign o_irq = r_irq;

  always_comb begin
    readdata = '0;
    if (chipselect && read) begin
      case (address)
        REG_ANGLE:  readdata = r_angle;
        REG_CTRL:   readdata = DATA_W'({r_auto, r_irq_en, 1'b0});
        REG_STATUS: readdata = DATA_W'({r_ovr, r_tmo, r_done, i_busy});
        REG_COS:    readdata = r_cos;
        REG_SIN:    readdata = r_sin;
        REG_ITER:   readdata = r_iter;
        default:    readdata = '0;
      endcase
    end
  end

endmodule

// File: rtl/nios2_cordic_ctrl.sv
// Avalon-MM controller that launches the iterative CORDIC core, waits for
// completion under a timeout and hands results to the register file.
module nios2_cordic_ctrl
  import nios2_cordic_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  input  logic              read,
  output logic [DATA_W-1:0] readdata,
  output logic              irq,
  output logic              core_start,
  output logic [DATA_W-1:0] core_angle,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_cos,
  input  logic [DATA_W-1:0] core_sin
);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_core_start;
  logic [DATA_W-1:0] r_core_angle;

  logic              w_busy;
  logic              w_start;
  logic              w_capture;
  logic              w_timeout;
  logic [DATA_W-1:0] w_start_angle;

  assign w_busy    = (r_state != S_IDLE);
  assign w_capture = (r_state == S_WAIT) & core_done;
  // Completion on the final WAIT cycle takes priority over the timeout.
  assign w_timeout = (r_state == S_WAIT) & ~core_done & (r_cnt == CNT_W'(TIMEOUT - 1));

  nios2_cordic_ctrl_regs #(
    .DATA_W(DATA_W)
  ) u_regs (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (address),
    .chipselect    (chipselect),
    .write         (write),
    .writedata     (writedata),
    .read          (read),
    .readdata      (readdata),
    .i_busy        (w_busy),
    .i_capture     (w_capture),
    .i_timeout     (w_timeout),
    .i_cos         (core_cos),
    .i_sin         (core_sin),
    .o_start       (w_start),
    .o_start_angle (w_start_angle),
    .o_irq         (irq)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_core_start <= 1'b0;
      r_core_angle <= '0;
    end else begin
      r_core_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_core_angle <= w_start_angle;
            r_core_start <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_capture || w_timeout) r_state <= S_IDLE;
          else                        r_cnt   <= r_cnt + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign core_start = r_core_start;
  assign core_angle = r_core_angle;

endmodule
